linebuf_ctrl: RTL
=================

Name: linebuf_ctrl

Overview:
- Ping-pong controller for the sprite scanline buffers: owns two single-port line-buffer banks.
- One bank is the render bank: the sprite engine writes pixels into it by read-modify-write, with first-written-wins priority.
- The other bank is the display bank: the video side reads one pixel per pixel strobe and clears each location right after reading it.
- Banks swap roles on every line_start pulse.
- Sits between the sprite renderer, the video mixer and the two line-buffer RAM instances.

Parameters:
- AW, 9, pixel x-address width; each bank is 2^AW entries.
- DW, 11, pixel word width.
- TW, 4, width of the colour-index field data[TW-1:0]; value 0 in this field means transparent.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- line_start  in  1  one-clock pulse at the start of hblank; swaps bank roles
- px_valid  in  1  render pixel offered
- px_x  in  AW  render pixel x position
- px_data  in  DW  render pixel word
- px_ready  out  1  controller can accept a render pixel this cycle
- pix_ce  in  1  display pixel strobe; pulses must be at least 2 clocks apart
- rd_x  in  AW  display x position, sampled when pix_ce=1
- rd_pix  out  DW  display pixel, registered
- overrun  out  1  sticky flag: a render pixel was aborted by line_start
- bank_sel  out  1  index of the current render bank
- b0_adr, b1_adr  out  AW  bank address
- b0_we, b1_we  out  1  bank write enable
- b0_wdat, b1_wdat  out  DW  bank write data
- b0_rdat, b1_rdat  in  DW  bank read data, valid one clock after the address is presented

Behaviour:
- Reset values:
  - bank_sel=0, rd_pix=0, overrun=0.
  - Render FSM in IDLE, so px_ready=1.
  - Clear pipeline empty.
  - All bank we=0; all bank adr and wdat=0.
- Bank mux: render bank = bank_sel, display bank = ~bank_sel. Bank outputs are combinational from the FSM and pipeline registers plus rd_x.
- Render FSM states are IDLE, RD, WR.
  - IDLE: px_ready=1, no render access.
    - px_valid with px_data[TW-1:0]==0: pixel discarded, stay in IDLE.
    - px_valid with a non-transparent pixel: latch x and data, go to RD.
  - RD: render bank adr=x, we=0; go to WR.
  - WR: if rdat[TW-1:0]==0, drive adr=x, we=1, wdat=data; otherwise no write. Return to IDLE.
  - Throughput is one non-transparent pixel per 3 clocks. px_ready=0 in RD and WR.
- Display pipeline:
  - Cycle where pix_ce=1: display bank adr=rd_x, we=0. Latch rd_x and the display bank index into clr_x and clr_bank; set clr_pend.
  - Next cycle:
    - rd_pix <= rdat of clr_bank.
    - Bank clr_bank gets adr=clr_x, we=1, wdat=0.
    - clr_pend clears.
  - rd_pix holds between strobes.
  - A pix_ce arriving while clr_pend=1 is a protocol violation; behaviour is undefined and the bench flags it.
- line_start:
  - bank_sel toggles on the clock edge.
  - If the render FSM is in RD or WR, it returns to IDLE with no write and overrun is set to 1. A WR cycle coincident with line_start is suppressed.
  - A pending clear completes on its latched clr_bank even though that bank has just become the render bank. No conflict is possible: the render FSM is in IDLE on that cycle and issues no access.
  - A px_valid in the same cycle as line_start is not accepted. px_ready is forced to 0 on that cycle.
- Per-bank access arbitration: each bank sees at most one access per cycle by construction. If a render access and a clear ever target the same bank on the same cycle, the clear wins.
- overrun is cleared only by reset.
- Asserting reset mid-operation abandons any in-flight write or clear; no bank write is issued while reset is high.

Test Plan:
- Reset, then idle: bank_sel=0, px_ready=1, rd_pix=0, all we=0, overrun=0.
- Render px_x=5, px_data=0x123 into bank 0 (b0_rdat=0 during the read): b0_we=1, b0_adr=5, b0_wdat=0x123 exactly 2 clocks after acceptance; px_ready low for 2 clocks.
- Priority: b0_rdat=0x045 in WR for px_data=0x7A1 → no write. Transparent pixel px_data=0x120 → never leaves IDLE, px_ready stays 1.
- Swap and display: line_start pulse → bank_sel=1. pix_ce with rd_x=5 and b0_rdat=0x123 → next clock rd_pix=0x123, b0_we=1, b0_adr=5, b0_wdat=0.
- line_start while render FSM is in RD → no render write, FSM in IDLE, overrun=1 and remains 1 until reset.
- line_start in the cycle before a pending clear → the clear is still written to the old display bank at the latched address. Render px_valid on the line_start cycle is not accepted.

Source files
------------

// File: rtl/linebuf_ctrl.sv
// Ping-pong controller for two single-port sprite line buffers: render bank takes
// read-modify-write pixels (first write wins), display bank is read and cleared.
module linebuf_ctrl #(
  parameter int AW = 9,
  parameter int DW = 11,
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          line_start,
  input  logic          px_valid,
  input  logic [AW-1:0] px_x,
  input  logic [DW-1:0] px_data,
  output logic          px_ready,
  input  logic          pix_ce,
  input  logic [AW-1:0] rd_x,
  output logic [DW-1:0] rd_pix,
  output logic          overrun,
  output logic          bank_sel,
  output logic [AW-1:0] b0_adr,
  output logic [AW-1:0] b1_adr,
  output logic          b0_we,
  output logic          b1_we,
  output logic [DW-1:0] b0_wdat,
  output logic [DW-1:0] b1_wdat,
  input  logic [DW-1:0] b0_rdat,
  input  logic [DW-1:0] b1_rdat
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] x_reg;
  logic [DW-1:0] data_reg;
  logic          bank_sel_reg;
  logic          clr_pend_reg;
  logic [AW-1:0] clr_x_reg;
  logic          clr_bank_reg;
  logic [DW-1:0] rd_pix_reg;
  logic          overrun_reg;

  logic [AW-1:0] bank_adr  [2];
  logic          bank_we   [2];
  logic [DW-1:0] bank_wdat [2];
  logic [DW-1:0] bank_rdat [2];
  logic [DW-1:0] render_rdat;
  logic          accept;
  logic          render_wr;

  assign bank_rdat[0] = b0_rdat;
  assign bank_rdat[1] = b1_rdat;
  assign render_rdat  = bank_rdat[bank_sel_reg];

  // line_start wins over a new pixel so nothing is accepted across a swap
  assign px_ready  = (state_reg == IDLE) && !line_start;
  assign accept    = px_valid && px_ready && (px_data[TW-1:0] != '0);
  assign render_wr = (state_reg == WR) && !line_start && (render_rdat[TW-1:0] == '0);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = RD;
      RD:      state_next = WR;
      WR:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (line_start) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      x_reg        <= '0;
      data_reg     <= '0;
      bank_sel_reg <= 1'b0;
      clr_pend_reg <= 1'b0;
      clr_x_reg    <= '0;
      clr_bank_reg <= 1'b0;
      rd_pix_reg   <= '0;
      overrun_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        x_reg    <= px_x;
        data_reg <= px_data;
      end
      if (line_start) begin
        bank_sel_reg <= ~bank_sel_reg;
        if (state_reg != IDLE) overrun_reg <= 1'b1;
      end
      clr_pend_reg <= pix_ce;
      if (pix_ce) begin
        clr_x_reg    <= rd_x;
        clr_bank_reg <= ~bank_sel_reg;
      end
      if (clr_pend_reg) rd_pix_reg <= bank_rdat[clr_bank_reg];
    end
  end

  // Per-bank port mux; later assignments take priority so a clear beats a render access
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    always_comb begin
      bank_adr[gi]  = '0;
      bank_we[gi]   = 1'b0;
      bank_wdat[gi] = '0;
      if (bank_sel_reg == 1'(gi) && (state_reg == RD || state_reg == WR)) begin
        bank_adr[gi] = x_reg;
        if (render_wr) begin
          bank_we[gi]   = 1'b1;
          bank_wdat[gi] = data_reg;
        end
      end
      if (pix_ce && bank_sel_reg != 1'(gi)) begin
        bank_adr[gi] = rd_x;
        bank_we[gi]  = 1'b0;
      end
      if (clr_pend_reg && clr_bank_reg == 1'(gi)) begin
        bank_adr[gi]  = clr_x_reg;
        bank_we[gi]   = 1'b1;
        bank_wdat[gi] = '0;
      end
    end
  end

  assign b0_adr   = bank_adr[0];
  assign b1_adr   = bank_adr[1];
  assign b0_we    = bank_we[0];
  assign b1_we    = bank_we[1];
  assign b0_wdat  = bank_wdat[0];
  assign b1_wdat  = bank_wdat[1];
  assign bank_sel = bank_sel_reg;
  assign rd_pix   = rd_pix_reg;
  assign overrun  = overrun_reg;

endmodule
